// File: rtl/obstacle_warn_ctrl.sv
// Multi-channel obstacle-warning controller: synchroniser, per-channel debounce and a
// priority FSM with hold-off. Define WARN_TONE_EN to gate the speaker with a square-wave tone.
module obstacle_warn_ctrl #(
   parameter int unsigned NUM_CH       = 3,
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned HOLD_CYC     = 8,
   parameter int unsigned TONE_DIV     = 16,
   localparam int unsigned IDXW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_CH-1:0] sensor_i,
   output logic [NUM_CH-1:0] speaker_o,
   output logic [IDXW-1:0]   active_idx_o,
   output logic              alert_o,
   output logic [7:0]        alert_cnt_o
);

   localparam int unsigned CNTW = ($clog2(DEBOUNCE_CYC) > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned HCW  = ($clog2(HOLD_CYC) > 1) ? $clog2(HOLD_CYC) : 1;

   if (NUM_CH < 2 || NUM_CH > 8 || DEBOUNCE_CYC < 1 || HOLD_CYC < 1 || TONE_DIV < 1)
   begin : g_bad_param
      $error("obstacle_warn_ctrl: parameter out of range");
   end

   typedef enum logic [1:0] {StIdle, StAlert, StHold} state_e;

   logic [NUM_CH-1:0] sync1_q, sync2_q;
   logic [NUM_CH-1:0] deb_q, deb_d;
   logic [CNTW-1:0]   deb_cnt_q [NUM_CH];
   logic [CNTW-1:0]   deb_cnt_d [NUM_CH];
   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [HCW-1:0]    hold_q, hold_d;
   logic [7:0]        cnt_d;
   logic [IDXW-1:0]   winner;
   logic              any_act;
   logic [NUM_CH-1:0] spk_d;
   logic [IDXW-1:0]   aidx_d;

   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == CNTW'(DEBOUNCE_CYC - 1)) begin
               deb_d[i]     = ~deb_q[i];
               deb_cnt_d[i] = '0;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + CNTW'(1);
            end
         end else begin
            deb_cnt_d[i] = '0;
         end
      end
   end

   // Descending scan so the lowest active index wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (deb_q[i]) winner = IDXW'(i);
      end
   end

   assign any_act = |deb_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      cnt_d   = alert_cnt_o;
      unique case (state_q)
         StIdle: begin
            if (any_act) begin
               state_d = StAlert;
               idx_d   = winner;
               if (alert_cnt_o != 8'hff) cnt_d = alert_cnt_o + 8'd1;
            end
         end
         StAlert: begin
            if (any_act) begin
               idx_d = winner;
            end else begin
               state_d = StHold;
               hold_d  = HCW'(HOLD_CYC - 1);
            end
         end
         StHold: begin
            if (any_act) begin
               state_d = StAlert;
               idx_d   = winner;
            end else if (hold_q == '0) begin
               state_d = StIdle;
            end else begin
               hold_d = hold_q - HCW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef WARN_TONE_EN
   localparam int unsigned TCW = ($clog2(TONE_DIV) > 1) ? $clog2(TONE_DIV) : 1;

   logic [TCW-1:0] tone_cnt_q, tone_cnt_d;
   logic           tone_q, tone_d;

   // Restart the tone on a fresh alert so the first phase is always silent.
   always_comb begin
      tone_cnt_d = tone_cnt_q;
      tone_d     = tone_q;
      if (state_q == StIdle && state_d == StAlert) begin
         tone_cnt_d = '0;
         tone_d     = 1'b0;
      end else if (tone_cnt_q == TCW'(TONE_DIV - 1)) begin
         tone_cnt_d = '0;
         tone_d     = ~tone_q;
      end else begin
         tone_cnt_d = tone_cnt_q + TCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else if (ena) begin
         tone_cnt_q <= tone_cnt_d;
         tone_q     <= tone_d;
      end
   end
`endif

   always_comb begin
      spk_d  = '0;
      aidx_d = '0;
      if (state_d != StIdle) begin
         spk_d  = NUM_CH'(1) << idx_d;
         aidx_d = idx_d;
      end
`ifdef WARN_TONE_EN
      spk_d = spk_d & {NUM_CH{tone_d}};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         deb_cnt_q    <= '{default: '0};
         state_q      <= StIdle;
         idx_q        <= '0;
         hold_q       <= '0;
         alert_cnt_o  <= '0;
         speaker_o    <= '0;
         active_idx_o <= '0;
         alert_o      <= 1'b0;
      end else if (ena) begin
         sync1_q      <= sensor_i;
         sync2_q      <= sync1_q;
         deb_q        <= deb_d;
         deb_cnt_q    <= deb_cnt_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         alert_cnt_o  <= cnt_d;
         speaker_o    <= spk_d;
         active_idx_o <= aidx_d;
         alert_o      <= (state_d != StIdle);
      end
   end

endmodule

// File: doc/obstacle_warn_ctrl.md
Name: obstacle_warn_ctrl

Overview:
- Parametrised multi-sensor obstacle-warning controller. Successor to the 3-sensor priority state machine.
- NUM_CH LIDAR "object close" inputs pass through a synchroniser and a per-channel debounce.
- Output is a registered one-hot speaker enable for the highest-priority active channel, plus a hold-off so the warning does not chatter.
- Sits between the ui_in sensor pins and the uo_out speaker drivers in the top-level tile.

Parameters:
- NUM_CH, 3: number of sensor/speaker channels (2..8); channel 0 has highest priority.
- DEBOUNCE_CYC, 4: consecutive enabled cycles a synchronised input must differ from its debounced value before that value flips (>=1).
- HOLD_CYC, 8: enabled cycles the last speaker stays on after all sensors clear (>=1).
- TONE_DIV, 16: half-period of the tone square wave in enabled cycles (>=1); used only with the optional feature.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
- ena, input, 1: clock enable; when low, every register holds its value and outputs stay frozen.
- sensor_i, input, NUM_CH: raw asynchronous sensor levels; 1 = object close.
- speaker_o, output, NUM_CH: registered one-hot (or zero) speaker enables.
- active_idx_o, output, IDXW = max(1, clog2(NUM_CH)): index of the channel currently driving a speaker; 0 in IDLE.
- alert_o, output, 1: high whenever FSM is not IDLE.
- alert_cnt_o, output, 8: saturating count of IDLE->ALERT transitions.

Behaviour:
- Reset values: speaker_o=0, active_idx_o=0, alert_o=0, alert_cnt_o=0, FSM=IDLE, synchronisers=0, debounced=0, all counters=0.
- Sync: 2-flop synchroniser per channel.
- Debounce, per channel:
  - If sync differs from debounced, the counter increments.
  - When the counter equals DEBOUNCE_CYC-1 and the inputs still differ, debounced flips and the counter clears.
  - If sync equals debounced, the counter clears.
- Winner: the lowest index with debounced=1. any_act = OR of all debounced bits.
- Latency: let edge 1 be the first edge sampling the new sensor level. speaker_o reflects it after edge DEBOUNCE_CYC+3 (edge 7 at defaults).
- FSM states, all evaluated only when ena=1:
  - IDLE: if any_act, go to ALERT, latch idx=winner, increment alert_cnt_o (saturating at 255). Otherwise stay.
  - ALERT: if any_act, idx=winner; the new winner takes effect the next cycle, for both pre-emption by a lower index and fall-back to a higher index. If !any_act, go to HOLD and load hold counter = HOLD_CYC-1.
  - HOLD: if any_act, go to ALERT with idx=winner (alert_cnt_o is NOT incremented). Else if hold counter = 0, go to IDLE. Else decrement.
- Outputs, registered from next state:
  - speaker_o = one-hot(idx) in ALERT/HOLD, else 0.
  - active_idx_o = idx in ALERT/HOLD, else 0.
  - alert_o = (state != IDLE).
- Simultaneous inputs: only the lowest index sounds; a higher-index channel is never shown while a lower one is debounced-active.
- Reset mid-alert: outputs go to 0 asynchronously. After release, the synchroniser and debounce restart from 0, so the full latency applies again.
- ena low: synchroniser, debounce, hold and tone counters all freeze; no input is lost beyond the synchroniser's held sample.

Optional Feature:
- Macro WARN_TONE_EN.
- Defined:
  - Free-running tone counter toggles a tone bit every TONE_DIV enabled cycles.
  - speaker_o = one-hot(idx) AND tone, giving an audible square wave of period 2*TONE_DIV.
  - Tone counter and tone bit reset to 0 on entry to ALERT from IDLE, so the first tone phase is silent for TONE_DIV cycles.
- Undefined: speaker_o is a steady level as described above; no tone logic is synthesised.

Test Plan:
1. Reset then sensor_i=3'b010 held, defaults, ena=1 -> speaker_o=3'b010, active_idx_o=1, alert_o=1 after edge 7; alert_cnt_o=1.
2. Glitch: sensor_i[0] high for 3 cycles then low -> speaker_o stays 0, alert_cnt_o=0.
3. Priority: sensor_i=3'b110 steady, then bit0 set -> speaker_o 3'b010 becomes 3'b001 DEBOUNCE_CYC+3 edges after bit0 rises; release bit0 -> returns to 3'b010.
4. Hold: sensor_i goes from 3'b100 to 0 -> speaker_o=3'b100 persists 8 cycles in HOLD, then 0 and alert_o=0. Re-assert during HOLD -> returns to ALERT, alert_cnt_o unchanged.
5. ena low for 20 cycles mid-HOLD -> all outputs frozen; HOLD resumes with the remaining count when ena returns. Assert rst_n=0 mid-ALERT -> outputs 0 without a clock edge.
6. WARN_TONE_EN, TONE_DIV=2, sensor_i=3'b001 -> speaker_o[0] pattern 0,0,1,1,0,0,... starting at the ALERT entry cycle.
